// File: rtl/sram_write_slave.sv
// sram_write_slave
// ----------------
// AXI4 write-channel slave front end for the on-chip SRAM target. One burst
// is in flight at a time: the AW request is latched, the W beats are streamed
// into a single-port SRAM through a registered write port, and a single B
// response closes the burst. Read channels are handled elsewhere.
//
// Ports
//   ACLK, ARESET              clock (rising edge) and synchronous active-high reset
//   AW*   (in) / AWREADY      write address channel
//   W*    (in) / WREADY       write data channel
//   BID, BRESP, BVALID / BREADY   write response channel
//   SRAM_CEB, SRAM_WEB        active-low chip enable and per-byte write enables
//   SRAM_A, SRAM_DI           SRAM word address and write data
//
// Only 32-bit beats (AWSIZE=3'b010) with FIXED or INCR bursts are supported.
// Anything else, or a burst whose WLAST disagrees with AWLEN, is still drained
// to completion and answered with SLVERR. The SRAM is only written while the
// burst is error-free.

module sram_write_slave #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int ID_BITS        = 8,
  parameter int LEN_BITS       = 4,
  parameter int SRAM_ADDR_BITS = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // write address channel
  input  logic [ID_BITS-1:0]        AWID,
  input  logic [ADDR_BITS-1:0]      AWADDR,
  input  logic [LEN_BITS-1:0]       AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  // write data channel
  input  logic [DATA_BITS-1:0]      WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  // write response channel
  output logic [ID_BITS-1:0]        BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  // SRAM write port
  output logic                      SRAM_CEB,
  output logic [3:0]                SRAM_WEB,
  output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
  output logic [DATA_BITS-1:0]      SRAM_DI
);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_awready;
  logic r_wready;
  logic r_bvalid;

  logic [ID_BITS-1:0]        r_id;
  logic [SRAM_ADDR_BITS-1:0] r_ptr;
  logic [LEN_BITS-1:0]       r_len;
  logic [1:0]                r_burst;
  logic [LEN_BITS-1:0]       r_cnt;
  logic                      r_err;

  logic                      r_ceb;
  logic [3:0]                r_web;
  logic [SRAM_ADDR_BITS-1:0] r_a;
  logic [DATA_BITS-1:0]      r_di;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_b_fire;
  logic w_cnt_at_len;
  logic w_do_write;
  logic w_unused;

  assign w_aw_fire    = AWVALID & r_awready;
  assign w_w_fire     = WVALID & r_wready;
  assign w_b_fire     = r_bvalid & BREADY;
  assign w_cnt_at_len = (r_cnt == r_len);
  // The error flag in force before this beat decides whether it is written,
  // so the beat that first exposes an overrun or early WLAST still lands.
  assign w_do_write   = w_w_fire & ~r_err;

  // Byte-offset and upper address bits select the slave, not the word.
  assign w_unused = ^{AWADDR[ADDR_BITS-1:SRAM_ADDR_BITS+2], AWADDR[1:0]};

  // Next-state logic for the single-outstanding-burst sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_fire) w_next = S_WRITE;
      S_WRITE: if (w_w_fire && WLAST) w_next = S_RESP;
      S_RESP:  if (w_b_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register. The handshake flags are registered copies of the state
  // decode so that they read 0 while reset is held and rise only once the
  // block is genuinely sitting in the matching state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_awready <= (w_next == S_IDLE);
      r_wready  <= (w_next == S_WRITE);
      r_bvalid  <= (w_next == S_RESP);
    end
  end

  // Burst context: latched on AW acceptance, advanced on every accepted beat.
  // A mismatch between WLAST and the beat count (early WLAST, or a beat at the
  // final count without WLAST) poisons the rest of the burst.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_id    <= '0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (w_aw_fire) begin
      r_id    <= AWID;
      r_ptr   <= AWADDR[SRAM_ADDR_BITS+1:2];
      r_len   <= AWLEN;
      r_burst <= AWBURST;
      r_cnt   <= '0;
      r_err   <= (AWSIZE != SIZE_WORD) | AWBURST[1];
    end else if (w_w_fire) begin
      if (r_burst == BURST_INCR) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (!w_cnt_at_len) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (WLAST != w_cnt_at_len) begin
        r_err <= 1'b1;
      end
    end
  end

  // Registered SRAM write port: each good beat becomes a one-cycle enable
  // pulse the cycle after its handshake. Address and data hold between writes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_ceb <= 1'b1;
      r_web <= 4'hF;
      r_a   <= '0;
      r_di  <= '0;
    end else begin
      r_ceb <= ~w_do_write;
      r_web <= w_do_write ? ~WSTRB : 4'hF;
      if (w_do_write) begin
        r_a  <= r_ptr;
        r_di <= WDATA;
      end
    end
  end

  assign AWREADY  = r_awready;
  assign WREADY   = r_wready;
  assign BVALID   = r_bvalid;
  assign BID      = r_id;
  assign BRESP    = r_err ? RESP_SLV : RESP_OKAY;
  assign SRAM_CEB = r_ceb;
  assign SRAM_WEB = r_web;
  assign SRAM_A   = r_a;
  assign SRAM_DI  = r_di;

endmodule

// File: tb/tb_sram_write_slave.sv
// tb_sram_write_slave
// -------------------
// Drives AXI write bursts into sram_write_slave and checks the SRAM write
// port and B channel. Each burst's expected SRAM writes and B response are
// computed from the burst parameters and queued; a negedge monitor pops and
// compares them whenever the DUT presents a write or a response.

module tb_sram_write_slave;

  localparam int ADDR_BITS      = 32;
  localparam int DATA_BITS      = 32;
  localparam int ID_BITS        = 8;
  localparam int LEN_BITS       = 4;
  localparam int SRAM_ADDR_BITS = 14;

  logic                      ACLK;
  logic                      ARESET;
  logic [ID_BITS-1:0]        AWID;
  logic [ADDR_BITS-1:0]      AWADDR;
  logic [LEN_BITS-1:0]       AWLEN;
  logic [2:0]                AWSIZE;
  logic [1:0]                AWBURST;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_BITS-1:0]      WDATA;
  logic [3:0]                WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;
  logic [ID_BITS-1:0]        BID;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic                      SRAM_CEB;
  logic [3:0]                SRAM_WEB;
  logic [SRAM_ADDR_BITS-1:0] SRAM_A;
  logic [DATA_BITS-1:0]      SRAM_DI;

  sram_write_slave #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS),
    .LEN_BITS(LEN_BITS), .SRAM_ADDR_BITS(SRAM_ADDR_BITS)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [SRAM_ADDR_BITS-1:0] a;
    logic [DATA_BITS-1:0]      d;
    logic [3:0]                web;
  } wrT;

  typedef struct {
    logic [ID_BITS-1:0] id;
    logic [1:0]         resp;
  } rspT;

  wrT  wrQ[$];
  rspT rspQ[$];
  wrT  monWr;
  rspT monRsp;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name, input string what);
    checks++;
    fails++;
    $display("[TB] FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Monitor: every SRAM enable pulse must match the oldest queued write, idle
  // cycles must keep all byte enables off, and a presented B response must
  // match the oldest queued response on every cycle it is held.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (SRAM_CEB == 1'b0) begin
        if (wrQ.size() == 0) begin
          failNow("unexpectedWrite", $sformatf("got A=%h DI=%h WEB=%h, required no write", SRAM_A, SRAM_DI, SRAM_WEB));
        end else begin
          monWr = wrQ.pop_front();
          checkOutput("sramWrite", 64'({SRAM_A, SRAM_DI, SRAM_WEB}), 64'({monWr.a, monWr.d, monWr.web}));
        end
      end else begin
        checkOutput("sramIdleWeb", 64'(SRAM_WEB), 64'hF);
      end
      if (BVALID) begin
        if (rspQ.size() == 0) begin
          failNow("unexpectedB", $sformatf("got BID=%h BRESP=%b, required no response", BID, BRESP));
        end else begin
          monRsp = rspQ[0];
          checkOutput("bResponse", 64'({BID, BRESP}), 64'({monRsp.id, monRsp.resp}));
          if (BREADY) void'(rspQ.pop_front());
        end
      end
    end
  end

  task automatic sendAw(input logic [7:0] id, input logic [31:0] addr, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    bit hs = 1'b0;
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge ACLK);
      hs = AWREADY;
      @(posedge ACLK);
      #1;
    end
    AWVALID = 1'b0;
    if (!hs) failNow("awTimeout", "got no AWREADY within 50 cycles, required handshake");
  endtask

  task automatic sendW(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit hs = 1'b0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge ACLK);
      hs = WREADY;
      @(posedge ACLK);
      #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    if (!hs) failNow("wTimeout", "got no WREADY within 50 cycles, required handshake");
  endtask

  // One complete burst. The reference behaviour: a burst with a bad size or a
  // WRAP/reserved type writes nothing; otherwise beats 0..len are written
  // (to consecutive words for INCR, to one word for FIXED) and later beats
  // are dropped; the response is SLVERR unless the config is good and the
  // beat count equals len+1. gap<0 means random gaps of 0..2 cycles.
  task automatic applyStimulus(input logic [7:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input int nBeats,
                               input int gap, input int breadyDelay,
                               input bit forceStrb, input logic [3:0] strbVal);
    bit                        bad;
    logic [SRAM_ADDR_BITS-1:0] base;
    logic [31:0]               d;
    logic [3:0]                s;
    int                        g;
    int                        n;
    bad  = (size != 3'b010) || burst[1];
    base = addr[SRAM_ADDR_BITS+1:2];
    rspQ.push_back('{id: id, resp: (bad || nBeats != len + 1) ? 2'b10 : 2'b00});
    sendAw(id, addr, len, size, burst);
    for (int i = 0; i < nBeats; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        @(posedge ACLK);
        #1;
      end
      d = $urandom;
      s = forceStrb ? strbVal : 4'($urandom);
      sendW(d, s, i == nBeats - 1);
      if (!bad && i <= len) begin
        wrQ.push_back('{a: (burst == 2'b01) ? base + SRAM_ADDR_BITS'(i) : base, d: d, web: ~s});
      end
    end
    if (breadyDelay == 0) BREADY = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!BVALID) begin
      failNow("bTimeout", "got BVALID=0 for 50 cycles, required 1");
      rspQ.delete();
      wrQ.delete();
      BREADY = 1'b0;
      @(posedge ACLK);
      #1;
    end else begin
      for (int k = 0; k < breadyDelay; k++) begin
        @(posedge ACLK);
        #1;
        checkOutput("bvalidHeld", 64'(BVALID), 64'd1);
      end
      BREADY = 1'b1;
      @(posedge ACLK);
      #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      checkOutput("bvalidDropped", 64'(BVALID), 64'd0);
      checkOutput("awreadyReturn", 64'(AWREADY), 64'd1);
      checkOutput("writesDrained", 64'(wrQ.size()), 64'd0);
      checkOutput("respDrained", 64'(rspQ.size()), 64'd0);
      wrQ.delete();
      rspQ.delete();
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstAwready", 64'(AWREADY), 64'd0);
    checkOutput("rstWready", 64'(WREADY), 64'd0);
    checkOutput("rstBvalid", 64'(BVALID), 64'd0);
    checkOutput("rstBid", 64'(BID), 64'd0);
    checkOutput("rstBresp", 64'(BRESP), 64'd0);
    checkOutput("rstCeb", 64'(SRAM_CEB), 64'd1);
    checkOutput("rstWeb", 64'(SRAM_WEB), 64'hF);
    checkOutput("rstA", 64'(SRAM_A), 64'd0);
    checkOutput("rstDi", 64'(SRAM_DI), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rAddr;
    int          rLen;
    logic [2:0]  rSize;
    logic [1:0]  rBurst;
    int          rBeats;
    logic [31:0] d;

    ARESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
    AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkResetOutputs();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (2) begin
      @(posedge ACLK);
      #1;
    end

    // W offered while idle must not be taken.
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    @(negedge ACLK);
    checkOutput("idleWready", 64'(WREADY), 64'd0);
    checkOutput("idleAwready", 64'(AWREADY), 64'd1);
    @(posedge ACLK);
    #1;
    WVALID = 1'b0;

    $display("[TB] directed bursts");
    applyStimulus(8'h15, 32'h0001_0010, 0, 3'b010, 2'b01, 1, 0, 0, 1'b1, 4'hF);
    applyStimulus(8'h21, 32'h0001_0000, 3, 3'b010, 2'b01, 4, 1, 3, 1'b1, 4'hF);
    applyStimulus(8'h22, 32'h0001_0040, 0, 3'b010, 2'b01, 1, 0, 1, 1'b1, 4'b0101);
    applyStimulus(8'h23, 32'h0001_0080, 0, 3'b010, 2'b01, 1, 0, 0, 1'b1, 4'b0000);
    applyStimulus(8'h24, 32'h0001_0200, 2, 3'b010, 2'b00, 3, 0, 2, 1'b0, 4'h0);
    applyStimulus(8'h31, 32'h0001_0300, 2, 3'b001, 2'b01, 3, 0, 1, 1'b1, 4'hF);
    applyStimulus(8'h32, 32'h0001_0300, 3, 3'b010, 2'b10, 4, 0, 1, 1'b1, 4'hF);
    applyStimulus(8'h41, 32'h0001_0400, 3, 3'b010, 2'b01, 2, 0, 0, 1'b1, 4'hF);
    applyStimulus(8'h42, 32'h0001_0500, 1, 3'b010, 2'b01, 4, 0, 0, 1'b1, 4'hF);
    applyStimulus(8'h51, 32'h0001_FFFC, 1, 3'b010, 2'b01, 2, 0, 0, 1'b1, 4'hF);

    $display("[TB] reset during a burst");
    sendAw(8'h3C, 32'h0001_0100, 3, 3'b010, 2'b01);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      sendW(d, 4'hF, 1'b0);
      wrQ.push_back('{a: 14'h0040 + 14'(i), d: d, web: 4'h0});
    end
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    checkResetOutputs();
    checkOutput("preResetWrites", 64'(wrQ.size()), 64'd0);
    wrQ.delete();
    rspQ.delete();
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    applyStimulus(8'h3D, 32'h0001_0120, 1, 3'b010, 2'b01, 2, 0, 1, 1'b0, 4'h0);

    $display("[TB] random bursts");
    for (int t = 0; t < 25; t++) begin
      rAddr  = {16'h0001, 16'($urandom) & 16'hFFFC};
      rLen   = int'($urandom_range(0, 15));
      rSize  = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      rBurst = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      rBeats = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 18)) : rLen + 1;
      applyStimulus(8'($urandom), rAddr, rLen, rSize, rBurst, rBeats, -1,
                    int'($urandom_range(0, 3)), 1'b0, 4'h0);
    end

    repeat (3) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sram_write_slave.md
Name: sram_write_slave

Overview:
- AXI4 write-channel slave front end for the SRAM target (slave S1, 0x0001_xxxx).
- Sits directly downstream of the interconnect write arbitration/mux.
- Accepts one AW burst, streams the W beats into a single-port SRAM with a registered write port, then returns one B response.
- Read channels live in a separate block.

Parameters:
- ADDR_BITS, 32, AXI address width.
- DATA_BITS, 32, AXI data width; fixed 4 byte lanes.
- ID_BITS, 8, slave-side AWID/BID width (master ID extended by interconnect).
- LEN_BITS, 4, AWLEN width; bursts of 1..16 beats.
- SRAM_ADDR_BITS, 14, SRAM word-address width (64 KiB).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- AWID  in  ID_BITS  write ID.
- AWADDR  in  ADDR_BITS  burst start byte address.
- AWLEN  in  LEN_BITS  beats minus one.
- AWSIZE  in  3  beat size; only 3'b010 is supported.
- AWBURST  in  2  burst type: FIXED=00, INCR=01, WRAP=10 (unsupported).
- AWVALID  in  1  AW valid.
- AWREADY  out  1  AW ready.
- WDATA  in  DATA_BITS  write data.
- WSTRB  in  4  byte strobes.
- WLAST  in  1  last beat.
- WVALID  in  1  W valid.
- WREADY  out  1  W ready.
- BID  out  ID_BITS  response ID.
- BRESP  out  2  OKAY=00, SLVERR=10.
- BVALID  out  1  B valid.
- BREADY  in  1  B ready.
- SRAM_CEB  out  1  chip enable, active-low.
- SRAM_WEB  out  4  per-byte write enable, active-low.
- SRAM_A  out  SRAM_ADDR_BITS  word address.
- SRAM_DI  out  DATA_BITS  write data.

Behaviour:
- Reset values, all outputs: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, SRAM_CEB=1, SRAM_WEB=4'hF, SRAM_A=0, SRAM_DI=0.
  - Internal: state=IDLE, beat counter=0, error flag=0.
  - Reset mid-burst aborts the burst: no further SRAM writes, no B response.
- FSM states: IDLE, WRITE, RESP.
  - Outputs decoded from registered state: AWREADY=1 only in IDLE; WREADY=1 only in WRITE; BVALID=1 only in RESP.
- IDLE:
  - On AWVALID&&AWREADY, latch AWID, AWADDR[SRAM_ADDR_BITS+1:2] as word pointer, AWLEN, AWBURST.
  - Clear the beat counter.
  - Set the error flag if AWSIZE!=3'b010 or AWBURST is WRAP or 11.
  - Go to WRITE.
- WRITE, on each WVALID&&WREADY:
  - Next cycle: SRAM_CEB=0, SRAM_A=pointer, SRAM_DI=WDATA, SRAM_WEB=~WSTRB.
  - If the error flag is set: SRAM_CEB stays 1, SRAM_WEB stays F. Beats are still accepted and discarded.
  - Pointer update: INCR adds 1, wrapping modulo 2^SRAM_ADDR_BITS; FIXED holds.
  - Beat counter increments; it saturates at AWLEN and never wraps.
  - WSTRB=0 still pulses SRAM_CEB=0 with WEB=F, which is a no-op write.
- Cycles with no W handshake: SRAM_CEB=1 and SRAM_WEB=F. SRAM_A and SRAM_DI hold their last value.
- Burst termination:
  - The W handshake with WLAST=1 goes to RESP.
  - If beat counter != latched AWLEN at that beat (WLAST early), set the error flag.
  - A beat at count==AWLEN without WLAST also sets the error flag. The block stays in WRITE, keeps accepting but not writing beats until WLAST.
- Latency:
  - SRAM write occurs 1 cycle after the W handshake.
  - BVALID rises 1 cycle after the WLAST handshake, coincident with the final SRAM write.
- RESP:
  - BID = latched ID; BRESP = error flag ? 10 : 00.
  - BVALID held, with BID/BRESP stable, until BREADY.
  - BVALID&&BREADY returns to IDLE. AWREADY rises the following cycle.
  - There is no AW acceptance during WRITE/RESP (single outstanding burst).
- W beats arriving while in IDLE are not accepted (WREADY=0). A simultaneous AW and W in IDLE takes only AW.

Test Plan:
- Single write: AWADDR=0x0001_0010, AWLEN=0, AWID=0x15, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1 -> next cycle SRAM_CEB=0, SRAM_A=4, SRAM_WEB=0, SRAM_DI=DEADBEEF; then BVALID=1, BID=0x15, BRESP=00.
- INCR burst AWLEN=3 at 0x0001_0000, WVALID gapped every other cycle, BREADY delayed 3 cycles -> SRAM_A=0,1,2,3 each one cycle after its handshake; BVALID held 4 cycles; BRESP=00.
- Byte strobes WSTRB=4'b0101 -> SRAM_WEB=4'b1010. FIXED burst AWLEN=2 -> SRAM_A constant for all 3 writes.
- Error cases, each -> SRAM_CEB stays 1 for the whole burst, BRESP=10:
  - AWSIZE=3'b001.
  - AWBURST=WRAP.
- Length mismatch:
  - AWLEN=3 with WLAST on beat 2 -> RESP after beat 2, BRESP=10.
  - AWLEN=1 with WLAST on beat 4 -> 4 handshakes accepted, BRESP=10.
- INCR wrap at AWADDR=0x0001_FFFC, AWLEN=1 -> SRAM_A=0x3FFF then 0x0000. Separately, ARESET asserted mid-burst -> next cycle all outputs at reset values; a fresh AW is accepted afterwards.
